// File: rtl/rand_stall_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rand_stall_pkg
// Purpose  : Shared state encodings and random-mask bit positions for the
//            random-stall memory bridge.
// Revision : 1.0 - initial release
// ============================================================================
package rand_stall_pkg;

  // Instruction-channel FSM states
  localparam logic [1:0] I_IDLE = 2'd0;
  localparam logic [1:0] I_RD   = 2'd1;
  localparam logic [1:0] I_RESP = 2'd2;

  // Data-channel FSM states
  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_RD   = 2'd1;
  localparam logic [1:0] D_RESP = 2'd2;

  // Bit positions inside random_mask, one per stall gate
  localparam int MASK_INST_REQ = 0;
  localparam int MASK_INST_VLD = 1;
  localparam int MASK_MEM_RD   = 2;
  localparam int MASK_RD_VLD   = 3;
  localparam int MASK_MEM_WR   = 4;
  localparam int NUM_GATES     = 5;

endpackage
`default_nettype wire

// File: rtl/rand_stall_gate.sv
`default_nettype none
// ============================================================================
// Module   : rand_stall_gate
// Purpose  : One random-stall gate. Passes the mask bit as a permit, but
//            forces a permit once MAX_STALL consecutive armed cycles have
//            been refused, so a stall can never last forever.
// Revision : 1.0 - initial release
// ============================================================================
module rand_stall_gate #(
  parameter int MAX_STALL = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic mask_bit,
  input  logic armed,
  output logic permit
);

  // Counter must be able to hold MAX_STALL itself; a zero bound still needs one bit
  localparam int                 c_CNT_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);
  localparam logic [c_CNT_W-1:0] c_MAX   = c_CNT_W'(MAX_STALL);

  logic [c_CNT_W-1:0] r_cnt;

  // With MAX_STALL = 0 the counter is permanently at its limit, so permit is always high
  assign permit = mask_bit | (r_cnt == c_MAX);

  // Count refused armed cycles; any permit or a disarmed cycle restarts the run
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (armed && !permit) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rand_stall_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : rand_stall_mem_bridge
// Purpose  : Sim-only bridge between the CPU fetch/data handshakes and an
//            ideal synchronous-read RAM, inserting bounded random stalls on
//            every ready/valid edge under control of random_mask.
// Revision : 1.0 - initial release
// ============================================================================
module rand_stall_mem_bridge
  import rand_stall_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_AW     = 18,
  parameter int MAX_STALL  = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4:0]              random_mask,
  // instruction fetch channel
  input  logic                    inst_req_valid,
  input  logic [ADDR_WIDTH-1:0]   inst_addr,
  output logic                    inst_req_ready,
  output logic                    inst_valid,
  output logic [DATA_WIDTH-1:0]   instruction,
  input  logic                    inst_ready,
  // data channel
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_strb,
  output logic                    mem_req_ready,
  output logic                    read_data_valid,
  output logic [DATA_WIDTH-1:0]   read_data,
  input  logic                    read_data_ready,
  // RAM side
  output logic [RAM_AW-1:0]       inst_ram_addr,
  input  logic [DATA_WIDTH-1:0]   inst_ram_rdata,
  output logic [RAM_AW-1:0]       data_ram_addr,
  output logic                    data_ram_wen,
  output logic [DATA_WIDTH/8-1:0] data_ram_wstrb,
  output logic [DATA_WIDTH-1:0]   data_ram_wdata,
  input  logic [DATA_WIDTH-1:0]   data_ram_rdata,
  output logic                    err_proto
);

  logic [1:0]            r_inst_state;
  logic [1:0]            r_data_state;
  logic                  r_inst_valid;
  logic                  r_rd_valid;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_instruction;
  logic [DATA_WIDTH-1:0] r_read_data;

  logic [NUM_GATES-1:0]  w_armed;
  logic [NUM_GATES-1:0]  w_permit;
  logic                  w_inst_fire;
  logic                  w_mem_fire;
  logic                  w_wr_fire;
  logic                  w_rd_fire;

  // Byte-offset and high address bits never reach the word-indexed RAM
  logic w_unused_addr;
  assign w_unused_addr = ^{inst_addr[1:0], inst_addr[ADDR_WIDTH-1:RAM_AW+2],
                           mem_addr[1:0],  mem_addr[ADDR_WIDTH-1:RAM_AW+2]};

  // One bounded-stall gate per random_mask bit
  genvar gi;
  generate
    for (gi = 0; gi < NUM_GATES; gi++) begin : g_gate
      rand_stall_gate #(
        .MAX_STALL (MAX_STALL)
      ) u_gate (
        .clk      (clk),
        .reset    (reset),
        .mask_bit (random_mask[gi]),
        .armed    (w_armed[gi]),
        .permit   (w_permit[gi])
      );
    end
  endgenerate

  // A gate is armed only while its FSM is actually waiting on it; valid gates
  // arm already in the RAM-read cycle so an unstalled response appears at T+2
  always_comb begin
    w_armed                = '0;
    w_armed[MASK_INST_REQ] = (r_inst_state == I_IDLE) && inst_req_valid;
    w_armed[MASK_INST_VLD] = ((r_inst_state == I_RD) || (r_inst_state == I_RESP)) && !r_inst_valid;
    w_armed[MASK_MEM_RD]   = (r_data_state == D_IDLE) && mem_read && !mem_write;
    w_armed[MASK_RD_VLD]   = ((r_data_state == D_RD) || (r_data_state == D_RESP)) && !r_rd_valid;
    w_armed[MASK_MEM_WR]   = (r_data_state == D_IDLE) && mem_write;
  end

  // Request-ready decode: the only combinational paths to CPU-facing outputs
  always_comb begin
    inst_req_ready = !reset && (r_inst_state == I_IDLE) && w_permit[MASK_INST_REQ];
    mem_req_ready  = 1'b0;
    if (!reset && (r_data_state == D_IDLE)) begin
      if (mem_write) begin
        mem_req_ready = w_permit[MASK_MEM_WR];
      end else if (mem_read) begin
        mem_req_ready = w_permit[MASK_MEM_RD];
      end
    end
  end

  assign w_inst_fire = inst_req_valid && inst_req_ready;
  assign w_mem_fire  = mem_req_ready;
  assign w_wr_fire   = w_mem_fire && mem_write;
  assign w_rd_fire   = w_mem_fire && !mem_write && mem_read;

  // RAM addresses are presented only in the accepting cycle, zero otherwise
  assign inst_ram_addr  = w_inst_fire ? inst_addr[RAM_AW+1:2] : '0;
  assign data_ram_addr  = w_mem_fire  ? mem_addr[RAM_AW+1:2]  : '0;
  assign data_ram_wen   = w_wr_fire;
  assign data_ram_wstrb = w_wr_fire ? write_strb : '0;
  assign data_ram_wdata = w_wr_fire ? write_data : '0;

  assign inst_valid      = r_inst_valid;
  assign instruction     = r_instruction;
  assign read_data_valid = r_rd_valid;
  assign read_data       = r_read_data;
  assign err_proto       = r_err;

  // Fetch FSM: accept, capture the RAM word, then hold a sticky valid until taken
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inst_state  <= I_IDLE;
      r_inst_valid  <= 1'b0;
      r_instruction <= '0;
    end else begin
      case (r_inst_state)
        I_IDLE: begin
          if (w_inst_fire) begin
            r_inst_state <= I_RD;
          end
        end
        I_RD: begin
          r_instruction <= inst_ram_rdata;
          if (w_permit[MASK_INST_VLD]) begin
            r_inst_valid <= 1'b1;
          end
          r_inst_state <= I_RESP;
        end
        I_RESP: begin
          if (!r_inst_valid) begin
            if (w_permit[MASK_INST_VLD]) begin
              r_inst_valid <= 1'b1;
            end
          end else if (inst_ready) begin
            r_inst_valid <= 1'b0;
            r_inst_state <= I_IDLE;
          end
        end
        default: begin
          r_inst_state <= I_IDLE;
          r_inst_valid <= 1'b0;
        end
      endcase
    end
  end

  // Data FSM: writes complete in the accept cycle, reads mirror the fetch path
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_state <= D_IDLE;
      r_rd_valid   <= 1'b0;
      r_read_data  <= '0;
    end else begin
      case (r_data_state)
        D_IDLE: begin
          if (w_rd_fire) begin
            r_data_state <= D_RD;
          end
        end
        D_RD: begin
          r_read_data <= data_ram_rdata;
          if (w_permit[MASK_RD_VLD]) begin
            r_rd_valid <= 1'b1;
          end
          r_data_state <= D_RESP;
        end
        D_RESP: begin
          if (!r_rd_valid) begin
            if (w_permit[MASK_RD_VLD]) begin
              r_rd_valid <= 1'b1;
            end
          end else if (read_data_ready) begin
            r_rd_valid   <= 1'b0;
            r_data_state <= D_IDLE;
          end
        end
        default: begin
          r_data_state <= D_IDLE;
          r_rd_valid   <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag for a simultaneous read+write request; only reset clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if ((r_data_state == D_IDLE) && mem_read && mem_write) begin
      r_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rand_stall_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_rand_stall_mem_bridge
// Purpose  : Directed self-checking bench for rand_stall_mem_bridge with
//            simple synchronous-read RAM models on both channels.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rand_stall_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  random_mask;
  logic        inst_req_valid;
  logic [31:0] inst_addr;
  logic        inst_req_ready;
  logic        inst_valid;
  logic [31:0] instruction;
  logic        inst_ready;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] write_data;
  logic [3:0]  write_strb;
  logic        mem_req_ready;
  logic        read_data_valid;
  logic [31:0] read_data;
  logic        read_data_ready;
  logic [17:0] inst_ram_addr;
  logic [31:0] inst_ram_rdata;
  logic [17:0] data_ram_addr;
  logic        data_ram_wen;
  logic [3:0]  data_ram_wstrb;
  logic [31:0] data_ram_wdata;
  logic [31:0] data_ram_rdata;
  logic        err_proto;

  int n_asserts = 0;
  int n_fails   = 0;

  rand_stall_mem_bridge #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .RAM_AW     (18),
    .MAX_STALL  (15)
  ) u_dut (
    .clk             (clk),
    .reset           (reset),
    .random_mask     (random_mask),
    .inst_req_valid  (inst_req_valid),
    .inst_addr       (inst_addr),
    .inst_req_ready  (inst_req_ready),
    .inst_valid      (inst_valid),
    .instruction     (instruction),
    .inst_ready      (inst_ready),
    .mem_addr        (mem_addr),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .write_data      (write_data),
    .write_strb      (write_strb),
    .mem_req_ready   (mem_req_ready),
    .read_data_valid (read_data_valid),
    .read_data       (read_data),
    .read_data_ready (read_data_ready),
    .inst_ram_addr   (inst_ram_addr),
    .inst_ram_rdata  (inst_ram_rdata),
    .data_ram_addr   (data_ram_addr),
    .data_ram_wen    (data_ram_wen),
    .data_ram_wstrb  (data_ram_wstrb),
    .data_ram_wdata  (data_ram_wdata),
    .data_ram_rdata  (data_ram_rdata),
    .err_proto       (err_proto)
  );

  always #5 clk = ~clk;

  // Instruction ROM: word content is a tag plus its own index
  always @(posedge clk) begin
    inst_ram_rdata <= 32'hC0DE_0000 | {14'd0, inst_ram_addr};
  end

  // Small data RAM (16 words), cleared on the first edge, byte-strobed writes
  logic [31:0] dmem [0:15];
  logic        ram_inited = 1'b0;
  always @(posedge clk) begin
    if (!ram_inited) begin
      for (int k = 0; k < 16; k++) dmem[k] <= 32'h0;
      ram_inited <= 1'b1;
    end else begin
      data_ram_rdata <= dmem[data_ram_addr[3:0]];
      if (data_ram_wen) begin
        for (int b = 0; b < 4; b++) begin
          if (data_ram_wstrb[b]) dmem[data_ram_addr[3:0]][8*b +: 8] <= data_ram_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset           = 1'b1;
    random_mask     = 5'h1F;
    inst_req_valid  = 1'b1;
    inst_addr       = 32'h100;
    inst_ready      = 1'b0;
    mem_addr        = 32'h0;
    mem_read        = 1'b1;
    mem_write       = 1'b0;
    write_data      = 32'h0;
    write_strb      = 4'h0;
    read_data_ready = 1'b0;

    // Reset state, with requests pending so the ready checks are meaningful
    repeat (3) tick();
    #1;
    chk("rst_inst_req_ready", {31'd0, inst_req_ready}, 32'd0);
    chk("rst_mem_req_ready",  {31'd0, mem_req_ready},  32'd0);
    chk("rst_inst_valid",     {31'd0, inst_valid},     32'd0);
    chk("rst_read_data_valid",{31'd0, read_data_valid},32'd0);
    chk("rst_err_proto",      {31'd0, err_proto},      32'd0);
    chk("rst_instruction",    instruction,             32'd0);
    chk("rst_inst_ram_addr",  {14'd0, inst_ram_addr},  32'd0);
    chk("rst_data_ram_wen",   {31'd0, data_ram_wen},   32'd0);
    inst_req_valid = 1'b0;
    mem_read       = 1'b0;
    reset          = 1'b0;
    tick();

    // 1: zero-stall fetch of 0x100
    inst_req_valid = 1'b1;
    inst_addr      = 32'h100;
    #1;
    chk("t1_inst_req_ready", {31'd0, inst_req_ready}, 32'd1);
    chk("t1_inst_ram_addr",  {14'd0, inst_ram_addr},  32'h40);
    tick();
    inst_req_valid = 1'b0;
    #1;
    chk("t1_valid_T1", {31'd0, inst_valid}, 32'd0);
    tick();
    #1;
    chk("t1_valid_T2",       {31'd0, inst_valid}, 32'd1);
    chk("t1_instruction_T2", instruction,         32'hC0DE_0040);
    inst_req_valid = 1'b1;
    #1;
    chk("t1_no_ready_in_resp", {31'd0, inst_req_ready}, 32'd0);
    inst_req_valid = 1'b0;
    inst_ready     = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1;
    chk("t1_valid_after_take", {31'd0, inst_valid}, 32'd0);

    // 2: valid gate held closed, stall bounded at 15 cycles in I_RESP
    random_mask    = 5'h1D;
    inst_req_valid = 1'b1;
    inst_addr      = 32'h204;
    #1;
    chk("t2_inst_req_ready", {31'd0, inst_req_ready}, 32'd1);
    tick();
    inst_req_valid = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) begin
      #1;
      chk($sformatf("t2_stall_low_%0d", i), {31'd0, inst_valid}, 32'd0);
      tick();
    end
    #1;
    chk("t2_valid_after_bound", {31'd0, inst_valid}, 32'd1);
    chk("t2_instruction",       instruction,         32'hC0DE_0081);
    inst_ready = 1'b1;
    tick();
    inst_ready  = 1'b0;
    random_mask = 5'h1F;

    // 4: partial-strobe write, passed through in the accept cycle
    mem_write  = 1'b1;
    mem_addr   = 32'h2004;
    write_data = 32'hDEAD_BEEF;
    write_strb = 4'b0011;
    #1;
    chk("t4_mem_req_ready", {31'd0, mem_req_ready},  32'd1);
    chk("t4_wen",           {31'd0, data_ram_wen},   32'd1);
    chk("t4_ram_addr",      {14'd0, data_ram_addr},  32'h801);
    chk("t4_wstrb",         {28'd0, data_ram_wstrb}, 32'h3);
    chk("t4_wdata",         data_ram_wdata,          32'hDEAD_BEEF);
    tick();
    mem_write  = 1'b0;
    write_strb = 4'h0;
    #1;
    chk("t4_no_rvalid_1", {31'd0, read_data_valid}, 32'd0);
    tick();
    #1;
    chk("t4_no_rvalid_2", {31'd0, read_data_valid}, 32'd0);
    chk("t4_wen_idle",    {31'd0, data_ram_wen},    32'd0);

    // Read gate closed -> no accept; reopening accepts in the same cycle
    random_mask = 5'h1B;
    mem_read    = 1'b1;
    mem_addr    = 32'h4;
    #1;
    chk("rd_gate_closed", {31'd0, mem_req_ready}, 32'd0);
    random_mask = 5'h1F;
    #1;
    chk("rd_gate_open",   {31'd0, mem_req_ready}, 32'd1);
    chk("rd_ram_addr",    {14'd0, data_ram_addr}, 32'h1);
    tick();
    mem_read = 1'b0;
    tick();
    #1;
    chk("t3_rvalid_T2", {31'd0, read_data_valid}, 32'd1);
    chk("t3_rdata_T2",  read_data,                32'h0000_BEEF);

    // 3: valid/data stay put while the CPU back-pressures and mask[3] toggles
    for (int i = 0; i < 5; i++) begin
      random_mask = (i % 2 == 0) ? 5'h17 : 5'h1F;
      #1;
      chk($sformatf("t3_hold_valid_%0d", i), {31'd0, read_data_valid}, 32'd1);
      chk($sformatf("t3_hold_data_%0d", i),  read_data,                32'h0000_BEEF);
      tick();
    end
    random_mask     = 5'h1F;
    read_data_ready = 1'b1;
    tick();
    read_data_ready = 1'b0;
    #1;
    chk("t3_rvalid_after_take", {31'd0, read_data_valid}, 32'd0);

    // 5: read and write together -> write wins, sticky error
    mem_read   = 1'b1;
    mem_write  = 1'b1;
    mem_addr   = 32'h8;
    write_data = 32'hCAFE_F00D;
    write_strb = 4'hF;
    #1;
    chk("t5_wen",       {31'd0, data_ram_wen}, 32'd1);
    chk("t5_err_early", {31'd0, err_proto},    32'd0);
    tick();
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    write_strb = 4'h0;
    #1;
    chk("t5_err_set",   {31'd0, err_proto},       32'd1);
    chk("t5_no_rvalid", {31'd0, read_data_valid}, 32'd0);
    repeat (100) tick();
    #1;
    chk("t5_err_sticky", {31'd0, err_proto}, 32'd1);

    // 6: reset while a read response is pending
    mem_read = 1'b1;
    mem_addr = 32'h8;
    #1;
    chk("t6_ready", {31'd0, mem_req_ready}, 32'd1);
    tick();
    mem_read = 1'b0;
    tick();
    #1;
    chk("t6_rvalid_pre", {31'd0, read_data_valid}, 32'd1);
    chk("t6_rdata_pre",  read_data,                32'hCAFE_F00D);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t6_rvalid_reset", {31'd0, read_data_valid}, 32'd0);
    chk("t6_rdata_reset",  read_data,                32'd0);
    chk("t6_err_reset",    {31'd0, err_proto},       32'd0);
    mem_read = 1'b1;
    mem_addr = 32'h4;
    #1;
    chk("t6_ready_after", {31'd0, mem_req_ready}, 32'd1);
    tick();
    mem_read = 1'b0;
    tick();
    #1;
    chk("t6_rvalid_new", {31'd0, read_data_valid}, 32'd1);
    chk("t6_rdata_new",  read_data,                32'h0000_BEEF);
    read_data_ready = 1'b1;
    tick();
    read_data_ready = 1'b0;
    #1;
    chk("t6_rvalid_done", {31'd0, read_data_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
